// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-controller line-fill path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_pkg;

  localparam int TAG_W      = 17;
  localparam int IDX_W      = 9;
  localparam int OFF_W      = 6;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = TAG_W + IDX_W + OFF_W;
  localparam int LINE_BYTES = 2 ** OFF_W;
  localparam int BEATS      = LINE_BYTES * 8 / DATA_W;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LINE_W     = DATA_W * BEATS;

  localparam logic [1:0]        BURST_INCR = 2'b01;
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [7:0]        AR_LEN     = 8'(BEATS - 1);
  localparam logic [2:0]        AR_SIZE    = 3'($clog2(DATA_W / 8));
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_AR,
    FILL_R,
    FILL_WR
  } fill_state_e;

  // Line-aligned byte address of a cache line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cc_line_fill_if.sv
// AXI-style read address / read data channel used by the line-fill engine.
// Latency: n/a (wires only).
// Backpressure: arvalid/arready and rvalid/rready handshakes.
interface cc_line_fill_if;
  import cc_pkg::*;

  logic [ADDR_W-1:0] araddr_o;
  logic [7:0]        arlen_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o;
  logic              arvalid_o;
  logic              arready_i;
  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp_i;
  logic              rlast_i;
  logic              rvalid_i;
  logic              rready_o;

  modport master (
    output araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o,
    input  arready_i, rdata_i, rresp_i, rlast_i, rvalid_i
  );

  modport slave (
    input  araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o,
    output arready_i, rdata_i, rresp_i, rlast_i, rvalid_i
  );

endinterface

// File: rtl/cc_line_buffer.sv
// Beat-assembly buffer for one cache line: BEATS x DATA_W registers.
// Latency: write visible on the next cycle; reads are combinational.
// Backpressure: none; writes whenever wen is high.
module cc_line_buffer
  import cc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [BEAT_W-1:0] widx,
  input  logic [DATA_W-1:0] wdat,
  input  logic [BEAT_W-1:0] ridx,
  output logic [LINE_W-1:0] line,
  output logic [DATA_W-1:0] rword
);

  logic [DATA_W-1:0] slot_q [BEATS];

  // Store one beat into its slot; reset clears the whole line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS; i++) slot_q[i] <= '0;
    end else if (wen) begin
      slot_q[widx] <= wdat;
    end
  end

  // Flatten slots so beat k occupies bits [DATA_W*k +: DATA_W].
  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) line[i*DATA_W +: DATA_W] = slot_q[i];
  end

  assign rword = slot_q[ridx];

endmodule

// File: rtl/cc_line_fill.sv
// Miss-service engine: one INCR burst per miss, then a single-cycle tag+data SRAM write.
// Latency: miss to fill_done_o is 10 cycles with no AXI wait states.
// Backpressure: holds arvalid until arready; accepts R beats only when rvalid is high.
module cc_line_fill
  import cc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [OFF_W-1:0]  offset_i,
  output logic              busy_o,
  cc_line_fill_if.master    axi,
  output logic              data_wen_o,
  output logic [IDX_W-1:0]  data_waddr_o,
  output logic [LINE_W-1:0] data_wdata_o,
  output logic              tag_wen_o,
  output logic [IDX_W-1:0]  tag_waddr_o,
  output logic [TAG_W:0]    tag_wdata_o,
  output logic              fill_done_o,
  output logic              fill_err_o,
  output logic [DATA_W-1:0] word_o
);

  fill_state_e       state_q, state_d;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BEAT_W-1:0] word_sel_q;
  logic [BEAT_W-1:0] cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] buf_word;
  logic [LINE_W-1:0] buf_line;
  logic              beat_fire;
  logic              beat_bad;
  logic              burst_end;
  logic              in_wr;
  logic              unused_off;

  // Byte-within-word offset bits do not affect which word is returned.
  assign unused_off = ^offset_i[OFF_W-BEAT_W-1:0];

  assign beat_fire = (state_q == FILL_R) && axi.rvalid_i;
  // A beat is bad on a non-OKAY response or when rlast disagrees with the beat count.
  assign beat_bad  = (axi.rresp_i != RESP_OKAY) || (axi.rlast_i != (cnt_q == LAST_BEAT));
  assign burst_end = beat_fire && (axi.rlast_i || (cnt_q == LAST_BEAT));
  assign in_wr     = (state_q == FILL_WR);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FILL_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake / write-strobe outputs.
  always_comb begin
    state_d        = state_q;
    busy_o         = 1'b1;
    axi.arvalid_o  = 1'b0;
    axi.rready_o   = 1'b0;
    data_wen_o     = 1'b0;
    tag_wen_o      = 1'b0;
    fill_done_o    = 1'b0;
    fill_err_o     = 1'b0;
    unique case (state_q)
      FILL_IDLE: begin
        busy_o = 1'b0;
        if (miss_i) state_d = FILL_AR;
      end
      FILL_AR: begin
        axi.arvalid_o = 1'b1;
        if (axi.arready_i) state_d = FILL_R;
      end
      FILL_R: begin
        axi.rready_o = 1'b1;
        if (burst_end) state_d = FILL_WR;
      end
      FILL_WR: begin
        data_wen_o  = 1'b1;
        tag_wen_o   = 1'b1;
        fill_done_o = 1'b1;
        fill_err_o  = err_q;
        state_d     = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // Capture the miss, count beats, track sticky error, and latch the returned word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q      <= '0;
      idx_q      <= '0;
      word_sel_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      if (state_q == FILL_IDLE && miss_i) begin
        tag_q      <= tag_i;
        idx_q      <= index_i;
        word_sel_q <= offset_i[OFF_W-1 -: BEAT_W];
        cnt_q      <= '0;
        err_q      <= 1'b0;
      end
      if (beat_fire) begin
        cnt_q <= cnt_q + BEAT_W'(1);
        if (beat_bad) err_q <= 1'b1;
      end
      if (in_wr) word_q <= buf_word;
    end
  end

  cc_line_buffer u_line_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (beat_fire),
    .widx  (cnt_q),
    .wdat  (axi.rdata_i),
    .ridx  (word_sel_q),
    .line  (buf_line),
    .rword (buf_word)
  );

  assign axi.araddr_o  = line_addr(tag_q, idx_q);
  assign axi.arlen_o   = AR_LEN;
  assign axi.arsize_o  = AR_SIZE;
  assign axi.arburst_o = BURST_INCR;

  assign data_waddr_o = idx_q;
  assign tag_waddr_o  = idx_q;
  assign data_wdata_o = buf_line;
  // An errored fill writes valid=0 so the entry is invalidated.
  assign tag_wdata_o  = in_wr ? {~err_q, tag_q} : '0;
  // The new word is visible during the write cycle and held afterwards.
  assign word_o       = in_wr ? buf_word : word_q;

endmodule

// File: tb/tb_cc_line_fill.sv
// Self-checking bench for cc_line_fill: directed scenarios plus randomized fills.
// Latency: n/a.
// Backpressure: bench acts as AXI slave with programmable AR and R stalls.
module tb_cc_line_fill;
  import cc_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              miss_i;
  logic [TAG_W-1:0]  tag_i;
  logic [IDX_W-1:0]  index_i;
  logic [OFF_W-1:0]  offset_i;
  logic              busy_o;
  logic              data_wen_o;
  logic [IDX_W-1:0]  data_waddr_o;
  logic [LINE_W-1:0] data_wdata_o;
  logic              tag_wen_o;
  logic [IDX_W-1:0]  tag_waddr_o;
  logic [TAG_W:0]    tag_wdata_o;
  logic              fill_done_o;
  logic              fill_err_o;
  logic [DATA_W-1:0] word_o;

  cc_line_fill_if axi ();

  cc_line_fill dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_i       (miss_i),
    .tag_i        (tag_i),
    .index_i      (index_i),
    .offset_i     (offset_i),
    .busy_o       (busy_o),
    .axi          (axi),
    .data_wen_o   (data_wen_o),
    .data_waddr_o (data_waddr_o),
    .data_wdata_o (data_wdata_o),
    .tag_wen_o    (tag_wen_o),
    .tag_waddr_o  (tag_waddr_o),
    .tag_wdata_o  (tag_wdata_o),
    .fill_done_o  (fill_done_o),
    .fill_err_o   (fill_err_o),
    .word_o       (word_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: line contents and the last returned word.
  logic [DATA_W-1:0] mline [BEATS];
  logic [DATA_W-1:0] mword;

  task automatic chk(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] model_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int i = 0; i < BEATS; i++) v[i*DATA_W +: DATA_W] = mline[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BEATS; i++) mline[i] = '0;
    mword = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},    busy_o, 0);
    chk({tag, "_arvalid"}, axi.arvalid_o, 0);
    chk({tag, "_araddr"},  axi.araddr_o, 0);
    chk({tag, "_arlen"},   axi.arlen_o, 7);
    chk({tag, "_arsize"},  axi.arsize_o, 3);
    chk({tag, "_arburst"}, axi.arburst_o, 1);
    chk({tag, "_rready"},  axi.rready_o, 0);
    chk({tag, "_dwen"},    data_wen_o, 0);
    chk({tag, "_twen"},    tag_wen_o, 0);
    chk({tag, "_daddr"},   data_waddr_o, 0);
    chk({tag, "_taddr"},   tag_waddr_o, 0);
    chk({tag, "_tdata"},   tag_wdata_o, 0);
    chk({tag, "_ddata"},   data_wdata_o, 0);
    chk({tag, "_done"},    fill_done_o, 0);
    chk({tag, "_err"},     fill_err_o, 0);
    chk({tag, "_word"},    word_o, 0);
  endtask

  // One miss and its AXI service. last_beat=BEATS means rlast never asserted;
  // err_beat<0 means no error response; abort_after>=0 resets after that many beats.
  task automatic run_fill(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix,
                          input logic [OFF_W-1:0] of, input int ar_delay,
                          input int last_beat, input int err_beat, input bit gaps,
                          input bit stray, input int abort_after, input int exp_done,
                          input bit seq_data);
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] beat;
    logic              exp_err;
    bit                ended;
    int                cyc;
    int                k;
    exp_addr = {t, ix, 6'h0};
    exp_err  = 1'b0;
    @(negedge clk);
    miss_i = 1'b1; tag_i = t; index_i = ix; offset_i = of;
    axi.arready_i = 1'b0; axi.rvalid_i = 1'b0;
    @(negedge clk);
    cyc = 1;
    miss_i = 1'b0;
    tag_i = TAG_W'($urandom); index_i = IDX_W'($urandom); offset_i = OFF_W'($urandom);
    chk("ar_busy", busy_o, 1);
    chk("ar_valid", axi.arvalid_o, 1);
    chk("ar_addr", axi.araddr_o, exp_addr);
    chk("ar_len", axi.arlen_o, 7);
    chk("ar_size", axi.arsize_o, 3);
    chk("ar_burst", axi.arburst_o, 1);
    chk("ar_rready", axi.rready_o, 0);
    for (int d = 0; d < ar_delay; d++) begin
      @(negedge clk);
      cyc++;
      chk("ar_hold_valid", axi.arvalid_o, 1);
      chk("ar_hold_addr", axi.araddr_o, exp_addr);
    end
    axi.arready_i = 1'b1;
    @(negedge clk);
    cyc++;
    axi.arready_i = 1'b0;
    chk("r_arvalid_low", axi.arvalid_o, 0);
    chk("r_rready", axi.rready_o, 1);
    k = 0;
    ended = 1'b0;
    while (!ended) begin
      if (abort_after == k) begin
        rst_n = 1'b0;
        axi.rvalid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_reset("abort");
        return;
      end
      if (gaps && k > 0) begin
        axi.rvalid_i = 1'b0;
        axi.rdata_i  = {$urandom, $urandom};
        axi.rlast_i  = 1'b1;
        axi.rresp_i  = 2'b10;
        @(negedge clk);
        cyc++;
        chk("gap_done", fill_done_o, 0);
        chk("gap_rready", axi.rready_o, 1);
      end
      beat = seq_data ? DATA_W'(k) : {$urandom, $urandom};
      axi.rvalid_i = 1'b1;
      axi.rdata_i  = beat;
      axi.rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
      axi.rlast_i  = (k == last_beat);
      if (stray && k == 2) begin
        miss_i = 1'b1; tag_i = ~t; index_i = ~ix;
      end
      mline[k] = beat;
      if (k == err_beat || ((k == last_beat) != (k == BEATS - 1))) exp_err = 1'b1;
      ended = (k == last_beat) || (k == BEATS - 1);
      k++;
      @(negedge clk);
      cyc++;
      miss_i = 1'b0;
      axi.rvalid_i = 1'b0; axi.rlast_i = 1'b0; axi.rresp_i = 2'b00;
    end
    mword = mline[of[5:3]];
    chk("wr_dwen", data_wen_o, 1);
    chk("wr_twen", tag_wen_o, 1);
    chk("wr_daddr", data_waddr_o, ix);
    chk("wr_taddr", tag_waddr_o, ix);
    chk("wr_tdata", tag_wdata_o, {~exp_err, t});
    chk("wr_ddata", data_wdata_o, model_line());
    chk("wr_done", fill_done_o, 1);
    chk("wr_err", fill_err_o, exp_err);
    chk("wr_word", word_o, mword);
    chk("wr_busy", busy_o, 1);
    chk("wr_rready", axi.rready_o, 0);
    if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
    @(negedge clk);
    chk("post_busy", busy_o, 0);
    chk("post_done", fill_done_o, 0);
    chk("post_err", fill_err_o, 0);
    chk("post_dwen", data_wen_o, 0);
    chk("post_twen", tag_wen_o, 0);
    chk("post_word", word_o, mword);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; miss_i = 1'b0; tag_i = '0; index_i = '0; offset_i = '0;
    axi.arready_i = 1'b0; axi.rdata_i = '0; axi.rresp_i = 2'b00;
    axi.rlast_i = 1'b0; axi.rvalid_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset("por");

    // Basic zero-wait fill with sequential data.
    run_fill(17'h1A2B3, 9'h05, 6'h18, 0, 7, -1, 1'b0, 1'b0, -1, 10, 1'b1);
    chk("basic_word_const", word_o, 64'h3);

    // AR stalled 3 cycles, R toggling valid.
    run_fill(17'h00F0F, 9'h1FF, 6'h38, 3, 7, -1, 1'b1, 1'b0, -1, 20, 1'b0);

    // SLVERR on beat 4, burst still completes.
    run_fill(17'h12345, 9'h0AA, 6'h20, 0, 7, 4, 1'b0, 1'b0, -1, 10, 1'b0);

    // Early rlast on beat 5.
    run_fill(17'h0BEEF, 9'h033, 6'h28, 0, 5, -1, 1'b0, 1'b0, -1, 8, 1'b0);

    // rlast missing on beat 7.
    run_fill(17'h1FFFF, 9'h100, 6'h00, 1, BEATS, -1, 1'b0, 1'b0, -1, 11, 1'b0);

    // Reset after 3 beats, then a clean fill.
    run_fill(17'h05555, 9'h0C3, 6'h08, 0, 7, -1, 1'b0, 1'b0, 3, -1, 1'b0);
    run_fill(17'h0AAAA, 9'h13C, 6'h10, 0, 7, -1, 1'b0, 1'b0, -1, 10, 1'b0);

    // Miss pulsed during R with a different tag is ignored.
    run_fill(17'h13579, 9'h0F0, 6'h30, 0, 7, -1, 1'b0, 1'b1, -1, 10, 1'b0);

    // Randomized fills.
    for (int n = 0; n < 16; n++) begin
      int lb;
      int eb;
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS)) : BEATS - 1;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
      run_fill(TAG_W'($urandom), IDX_W'($urandom), OFF_W'($urandom),
               int'($urandom_range(0, 3)), lb, eb, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cc_line_fill.md
Name: cc_line_fill

Overview:
- Miss-service and refill engine of the cache controller. It is the writer side of the tag/data SRAMs that the tag-compare stage reads.
- On a miss pulse it captures tag/index/offset and issues one AXI-style INCR read burst for the 64-byte line.
- It assembles the beats, then writes the data SRAM line and the tag SRAM entry {valid, tag} in a single cycle.
- It reports completion to the controller FSM, together with the originally requested 64-bit word.

Parameters:
- TAG_W, 17, tag width (address bits [31:15])
- IDX_W, 9, index width (address bits [14:6]); 512 lines
- OFF_W, 6, byte-offset width; 64-byte line
- DATA_W, 64, read-data bus width; BEATS = 2**OFF_W*8/DATA_W = 8

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- miss_i  in  1  one-cycle miss pulse
- tag_i  in  TAG_W  miss tag
- index_i  in  IDX_W  miss index
- offset_i  in  OFF_W  miss byte offset
- busy_o  out  1  high whenever state != IDLE
- araddr_o  out  32  line-aligned address {tag, index, 6'h0}
- arlen_o  out  8  BEATS-1 (8'd7)
- arsize_o  out  3  3'd3 (8 bytes per beat)
- arburst_o  out  2  2'b01 (INCR)
- arvalid_o  out  1  read-address valid
- arready_i  in  1  read-address ready
- rdata_i  in  DATA_W  read data
- rresp_i  in  2  read response; nonzero = error
- rlast_i  in  1  last beat
- rvalid_i  in  1  read-data valid
- rready_o  out  1  read-data ready
- data_wen_o  out  1  data SRAM write enable
- data_waddr_o  out  IDX_W  data SRAM line address
- data_wdata_o  out  DATA_W*BEATS  full line; beat k lands at bits [64k+63:64k]
- tag_wen_o  out  1  tag SRAM write enable
- tag_waddr_o  out  IDX_W  tag SRAM address
- tag_wdata_o  out  TAG_W+1  {valid, tag}
- fill_done_o  out  1  one-cycle completion pulse
- fill_err_o  out  1  one-cycle error pulse; coincides with fill_done_o
- word_o  out  DATA_W  requested word, line beat offset[5:3]; held until the next fill completes

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - All outputs 0 except the constants arlen_o, arsize_o and arburst_o.
  - Captured fields, beat counter, error flag and line buffer are cleared.
- Reset mid-operation aborts immediately. No SRAM write, no done pulse. Any outstanding AXI beats are the system's responsibility.
- States: IDLE, AR, R, WR.
- IDLE:
  - miss_i=1 registers tag/index/offset, clears beat count and error flag, then goes to AR.
  - arvalid_o is high in the cycle after miss_i.
- AR:
  - arvalid_o=1; araddr_o is stable while arvalid_o=1 and arready_i=0.
  - The handshake (arvalid_o && arready_i) moves to R.
- R:
  - rready_o=1.
  - Each rvalid_i beat is written into the line buffer slot for the current beat count, then the count increments (3-bit).
  - If rresp_i != 0 on any beat, the error flag is set (sticky).
  - Beat-count error: if rlast_i=1 on a beat other than beat 7, or rlast_i=0 on beat 7, the error flag is set.
  - The burst ends on the rlast_i beat, or on beat 7, whichever comes first. Either goes to WR.
- WR (exactly one cycle):
  - data_wen_o=1, tag_wen_o=1, both addressed by the captured index.
  - tag_wdata_o = {~err, tag}. An error fill writes valid=0, which invalidates the entry.
  - data_wdata_o = line buffer.
  - fill_done_o=1; fill_err_o = err.
  - word_o is updated from buffer slot offset[5:3].
  - Next state is IDLE.
- miss_i while busy_o=1 is ignored. The controller must not issue a miss while busy.
- Latency with zero wait states: miss at cycle 0, arvalid_o at 1, handshake at 1, beats at 2..9, WR/fill_done_o at 10, busy_o low at 11.
- rready_o is 0 outside R. rvalid_i outside R is ignored.

Decomposition:
- Shared package cc_pkg:
  - Address-split constants (TAG_W, IDX_W, OFF_W, LINE_BYTES).
  - AXI burst and resp localparams (BURST_INCR, RESP_OKAY).
  - Fill-state enum typedef.
- One natural sub-module, cc_line_buffer: an 8 x 64 register array with a beat write port, a flat 512-bit read, and a word-select read.

Test Plan:
- Basic fill: tag=17'h1A2B3, index=9'h05, offset=6'h18, arready=1, beats = 64'h0..07 with rresp=0 and rlast on beat 7.
  - araddr_o = 32'hD1598140, arlen_o = 7.
  - WR at cycle 10: tag_wdata_o = {1, 17'h1A2B3}, data_waddr_o = 5, word_o = 64'h3, fill_done_o=1, fill_err_o=0.
- Backpressure: arready_i held low 3 cycles, and rvalid_i toggles 1/0 across beats.
  - araddr_o and arvalid_o stable until the handshake.
  - All 8 beats land in order; done arrives 3 + 7 cycles later than the basic case.
- SLVERR on beat 4 (rresp=2'b10):
  - The burst completes.
  - tag_wdata_o valid bit = 0, data_wen_o=1, fill_done_o=1, fill_err_o=1.
- Early rlast on beat 5:
  - Goes to WR after beat 5 with fill_err_o=1 and a valid=0 tag.
  - busy_o is low on the following cycle.
- Reset mid-R after 3 beats:
  - All outputs 0, no SRAM write.
  - The next miss performs a clean fill with correct data.
- miss_i pulsed during R with a different tag:
  - Ignored; the original tag and index are written.
